// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its UART byte-stream front end:
// opcode values, default widths and the front-end FSM state encoding.
package alu_pkg;

  localparam int NB_DATA_DEFAULT = 8;
  localparam int NB_OP_DEFAULT   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

endpackage

// File: rtl/alu_uart_interface.sv
// Collects A, B and opcode bytes from uart_rx, presents them to the ALU,
// then latches the ALU result and hands it to uart_tx with a start/done handshake.
module alu_uart_interface
  import alu_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEFAULT,
  parameter int NB_OP   = NB_OP_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_op_err
);

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               op_err_q, op_err_d;

  logic [NB_OP-1:0]   op_byte;
  logic               op_valid;

  assign op_byte = i_rx_data[NB_OP-1:0];

  always_comb begin
    op_valid = 1'b0;
    case (op_byte)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRL, OP_SRA: op_valid = 1'b1;
      default:                        op_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    op_err_d   = op_err_q;
    case (state_q)
      ST_WAIT_A: begin
        if (i_rx_done) begin
          data_a_d = i_rx_data;
          state_d  = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done) begin
          data_b_d = i_rx_data;
          state_d  = ST_WAIT_OP;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          op_d = op_byte;
          if (op_valid) begin
            op_err_d = 1'b0;
            state_d  = ST_EXEC;
          end else begin
            op_err_d = 1'b1;
            state_d  = ST_WAIT_A;
          end
        end
      end
      ST_EXEC: begin
        // ALU inputs have been stable for a full cycle; result is settled.
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) state_d = ST_WAIT_A;
      end
      default: state_d = ST_WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_WAIT_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      op_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      op_err_q   <= op_err_d;
    end
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_op_err   = op_err_q;
  assign o_busy     = (state_q == ST_EXEC) || (state_q == ST_SEND) || (state_q == ST_WAIT_TX);

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: behavioural ALU in the feedback path, rx/tx pulse
// drivers, and a transaction-level expectation model.
module tb_alu_uart_interface;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] alu_result;
  logic       tx_done;
  logic [7:0] data_a, data_b, tx_data;
  logic [5:0] op;
  logic       tx_start, busy, op_err;

  int compared = 0;
  int mismatched = 0;
  int start_cnt = 0;

  logic [7:0] exp_a, exp_b, exp_tx;
  logic [5:0] exp_op;
  logic       exp_err;
  int         exp_starts;

  logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

  always #5 clk = ~clk;

  alu_uart_interface dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_rx_data   (rx_data),
    .i_rx_done   (rx_done),
    .i_alu_result(alu_result),
    .i_tx_done   (tx_done),
    .o_data_a    (data_a),
    .o_data_b    (data_b),
    .o_op        (op),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .o_busy      (busy),
    .o_op_err    (op_err)
  );

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] o);
    case (o)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> 1;
      6'h03:   return {a[7], a[7:1]};
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_ref(data_a, data_b, op);

  function automatic bit is_valid(input logic [5:0] o);
    foreach (valid_ops[i]) if (valid_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) if (tx_start === 1'b1) start_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // Called right after the opcode byte's rx pulse; mode 0 plain, 1 stray byte
  // in WAIT_TX, 2 stray byte coincident with tx_done.
  task automatic finish_txn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] o, input int mode);
    exp_a = a; exp_b = b; exp_op = o;
    check("data_a", data_a, exp_a);
    check("data_b", data_b, exp_b);
    check("op", op, exp_op);
    if (!is_valid(o)) begin
      exp_err = 1'b1;
      check("op_err_set", op_err, exp_err);
      check("idle_busy", busy, 1'b0);
      tick(); tick();
      check("no_start", start_cnt, exp_starts);
      return;
    end
    exp_err = 1'b0;
    exp_tx = alu_ref(a, b, o);
    check("op_err_clr", op_err, exp_err);
    check("exec_busy", busy, 1'b1);
    check("exec_nostart", tx_start, 1'b0);
    tick();
    exp_starts++;
    check("send_start", tx_start, 1'b1);
    check("tx_data", tx_data, exp_tx);
    tick();
    check("start_one_cycle", tx_start, 1'b0);
    check("start_count", start_cnt, exp_starts);
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
      check("wait_busy", busy, 1'b1);
      tick();
    end
    if (mode == 1) begin
      pulse_rx(8'h55);
      check("drop_a", data_a, exp_a);
      check("drop_busy", busy, 1'b1);
    end
    if (mode == 2) begin
      rx_data = $urandom;
      rx_done = 1'b1;
      tx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tx_done = 1'b0;
      check("coinc_a", data_a, exp_a);
    end else begin
      check("tx_hold", tx_data, exp_tx);
      pulse_tx_done();
    end
    check("done_busy", busy, 1'b0);
  endtask

  task automatic send_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ob, input int mode);
    pulse_rx(a);
    pulse_rx(b);
    pulse_rx(ob);
    finish_txn(a, b, ob[5:0], mode);
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    exp_starts = 0; exp_err = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_data_a", data_a, 8'h00);
    check("rst_op", op, 6'h00);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_start", tx_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", op_err, 1'b0);

    send_txn(8'h0A, 8'h05, 8'h20, 0);
    check("add_result", exp_tx, 8'h0F);
    send_txn(8'hF0, 8'h00, 8'h03, 0);
    check("sra_result", tx_data, 8'hF8);
    send_txn(8'hF0, 8'h00, 8'h02, 0);
    check("srl_result", tx_data, 8'h78);
    send_txn(8'h0C, 8'h03, 8'h3F, 0);
    check("inv_tx_kept", tx_data, 8'h78);
    send_txn(8'h0C, 8'h03, 8'h22, 1);
    check("sub_result", tx_data, 8'h09);
    send_txn(8'hAA, 8'hCC, 8'h24, 0);
    check("and_result", tx_data, 8'h88);

    // Reset mid-transaction, then the former opcode byte lands as operand A.
    pulse_rx(8'h01);
    pulse_rx(8'h02);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_err = 1'b0;
    check("mid_rst_a", data_a, 8'h00);
    check("mid_rst_b", data_b, 8'h00);
    check("mid_rst_tx", tx_data, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    pulse_rx(8'h20);
    check("post_rst_a", data_a, 8'h20);
    check("post_rst_busy", busy, 1'b0);
    tick(); tick(); tick();
    check("post_rst_nostart", start_cnt, exp_starts);
    pulse_rx(8'h03);
    pulse_rx(8'h20);
    finish_txn(8'h20, 8'h03, 6'h20, 0);

    // tx_done outside WAIT_TX is ignored.
    pulse_rx(8'hF0);
    pulse_tx_done();
    check("txd_waitb_busy", busy, 1'b0);
    check("txd_waitb_a", data_a, 8'hF0);
    pulse_rx(8'h0F);
    pulse_rx(8'h27);
    finish_txn(8'hF0, 8'h0F, 6'h27, 0);
    check("nor_result", tx_data, 8'h00);

    for (int t = 0; t < 40; t++) begin
      logic [7:0] ra, rb, ro;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 4) == 0) ro = 8'($urandom);
      else ro = {2'($urandom), valid_ops[$urandom_range(0, 7)]};
      pulse_rx(ra);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      pulse_rx(rb);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      pulse_rx(ro);
      finish_txn(ra, rb, ro[5:0], int'($urandom_range(0, 2)));
      check("rand_err", op_err, exp_err);
      check("rand_tx", tx_data, is_valid(ro[5:0]) ? alu_ref(ra, rb, ro[5:0]) : exp_tx);
    end
    tick();
    check("final_starts", start_cnt, exp_starts);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
